// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC and the branch-target table.
// It also holds each fetched word until the datapath accepts it.
module fetch_unit #(
  parameter int                  PC_WIDTH  = 10,
  parameter logic [PC_WIDTH-1:0] START_PC  = '0,
  parameter logic [8:0]          HALT_WORD = 9'h1FF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [8:0]          imem_data,
  output logic [8:0]          instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                branchEnable,
  input  logic [4:0]          LUTIndex,
  input  logic                lut_we,
  input  logic [4:0]          lut_waddr,
  input  logic [PC_WIDTH-1:0] lut_wdata,
  output logic [PC_WIDTH-1:0] pc,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    HOLD,
    DONE
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [PC_WIDTH-1:0] pc_n;
  logic                instr_ld;
  logic [PC_WIDTH-1:0] lut [32];

  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign done        = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (instr_ld) instr <= imem_data;
    end
  end

  // Branch reads see the pre-write contents in a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_ld = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = REQ;
          pc_n    = START_PC;
        end
      end
      REQ: state_n = LOAD;
      LOAD: begin
        state_n  = HOLD;
        instr_ld = 1'b1;
      end
      HOLD: begin
        if (instr_ready) begin
          unique case (1'b1)
            (instr == HALT_WORD): state_n = DONE;
            branchEnable: begin
              state_n = REQ;
              pc_n    = lut[LUTIndex];
            end
            default: begin
              state_n = REQ;
              pc_n    = pc + PC_WIDTH'(1);
            end
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic.
// A transaction-level model tracks valid, pc, instr, done and the table.
module tb_fetch_unit;

  localparam logic [8:0] HALT = 9'h1FF;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       branchEnable;
  logic [4:0] LUTIndex;
  logic       lut_we;
  logic [4:0] lut_waddr;
  logic [9:0] lut_wdata;
  logic [9:0] pc;
  logic       done;

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branchEnable(branchEnable),
    .LUTIndex(LUTIndex),
    .lut_we(lut_we),
    .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata),
    .pc(pc),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [8:0] mem [1024];
  always @(posedge clk) imem_data <= mem[imem_addr];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;

  // Model: m_wait counts edges until the pending word becomes valid.
  logic       m_valid;
  logic       m_done;
  logic [9:0] m_pc;
  logic [8:0] m_instr;
  int         m_wait;
  logic [9:0] m_lut [32];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_done  = 0;
    m_pc    = '0;
    m_instr = '0;
    m_wait  = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = '0;
  endtask

  task automatic step();
    logic [9:0] tgt;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      tgt = m_lut[LUTIndex];
      if (m_valid) begin
        if (instr_ready) begin
          m_valid = 0;
          if (m_instr == HALT) m_done = 1;
          else begin
            m_pc   = branchEnable ? tgt : m_pc + 10'd1;
            m_wait = 2;
          end
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1;
          m_instr = mem[m_pc];
        end
      end else if (start) begin
        m_pc   = 10'd0;
        m_done = 0;
        m_wait = 2;
      end
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
    end
    @(negedge clk);
    cyc++;
    check("valid", instr_valid, m_valid);
    check("done", done, m_done);
    check("pc", pc, m_pc);
    check("addr", imem_addr, m_pc);
    check("instr", instr, m_instr);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, instr_valid, 1);
  endtask

  task automatic clr_in();
    start        = 0;
    instr_ready  = 0;
    branchEnable = 0;
    LUTIndex     = '0;
    lut_we       = 0;
    lut_waddr    = '0;
    lut_wdata    = '0;
  endtask

  initial begin
    int n;
    clr_in();
    reset = 1;
    model_reset();
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    mem[0] = 9'h003;
    mem[1] = 9'h004;
    mem[2] = HALT;
    @(negedge clk);
    step();
    reset = 0;
    start = 1;
    step();
    start = 0;
    instr_ready = 1;
    while (cyc < 11) begin
      step();
      if (cyc == 4) check("s1_i0", instr, 9'h003);
      if (cyc == 7) check("s1_i1", instr, 9'h004);
      if (cyc == 10) check("s1_i2", instr, HALT);
    end
    check("s1_done", done, 1);
    check("s1_pc", pc, 10'd2);

    mem[0] = 9'h010;
    mem[1] = 9'h011;
    mem[2] = 9'h012;
    mem[3] = 9'h013;
    mem[10'h040] = 9'h020;
    mem[10'h041] = 9'h021;
    mem[10'h3FF] = 9'h055;
    mem[10'h100] = HALT;
    reset = 1;
    instr_ready = 0;
    step();
    reset = 0;
    lut_we = 1;
    lut_waddr = 5;
    lut_wdata = 10'h040;
    start = 1;
    step();
    clr_in();
    n = 0;
    while (!(m_valid && m_pc == 10'd3) && n < 40) begin
      instr_ready = 1;
      step();
      n++;
    end
    check("s2_reach", pc, 10'd3);
    instr_ready = 1;
    branchEnable = 1;
    LUTIndex = 5;
    lut_we = 1;
    lut_waddr = 5;
    lut_wdata = 10'h155;
    step();
    check("s2_tgt", imem_addr, 10'h040);
    clr_in();

    wait_valid("s3_wait");
    repeat (4) begin
      branchEnable = 1'($urandom);
      LUTIndex = 5'($urandom);
      step();
      check("s3_instr", instr, 9'h020);
      check("s3_pc", pc, 10'h040);
    end
    instr_ready = 1;
    branchEnable = 0;
    step();
    check("s3_next", imem_addr, 10'h041);
    clr_in();
    lut_we = 1;
    lut_waddr = 7;
    lut_wdata = 10'h3FF;
    step();
    lut_we = 0;

    wait_valid("s4_wait0");
    instr_ready = 1;
    branchEnable = 1;
    LUTIndex = 7;
    step();
    check("s4_tgt", imem_addr, 10'h3FF);
    clr_in();
    wait_valid("s4_wait1");
    check("s4_instr", instr, 9'h055);
    instr_ready = 1;
    step();
    check("s4_wrap", imem_addr, 10'h000);
    clr_in();

    step();
    reset = 1;
    step();
    reset = 0;
    check("s5_valid", instr_valid, 0);
    check("s5_pc", pc, 10'd0);
    start = 1;
    step();
    start = 0;
    step();
    step();
    check("s5_lat", instr_valid, 1);
    check("s5_instr", instr, 9'h010);
    instr_ready = 1;
    branchEnable = 1;
    LUTIndex = 7;
    step();
    check("s5_lutclr", imem_addr, 10'h000);
    clr_in();

    wait_valid("s6_wait0");
    start = 1;
    lut_we = 1;
    lut_waddr = 9;
    lut_wdata = 10'h100;
    step();
    clr_in();
    check("s6_ign", instr_valid, 1);
    instr_ready = 1;
    branchEnable = 1;
    LUTIndex = 9;
    step();
    clr_in();
    wait_valid("s6_wait1");
    check("s6_halt", instr, HALT);
    instr_ready = 1;
    step();
    instr_ready = 0;
    check("s6_done", done, 1);
    check("s6_pc", pc, 10'h100);
    start = 1;
    step();
    start = 0;
    check("s6_clr", done, 0);
    check("s6_addr", imem_addr, 10'h000);

    reset = 1;
    step();
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT
                                            : 9'($urandom_range(0, 510));
    for (int k = 0; k < 3000; k++) begin
      reset        = ($urandom_range(0, 99) < 2);
      start        = ($urandom_range(0, 3) == 0);
      instr_ready  = 1'($urandom);
      branchEnable = ($urandom_range(0, 3) == 0);
      LUTIndex     = 5'($urandom);
      lut_we       = ($urandom_range(0, 4) == 0);
      lut_waddr    = 5'($urandom);
      lut_wdata    = 10'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer that supplies the 9-bit instruction word (`instr`) consumed by the control decoder, and acts on the decoder's `branchEnable` / `LUTIndex` outputs to pick the next PC. It owns the program counter and a 32-entry branch-target lookup table. It drives a synchronous instruction memory and holds each word until the datapath accepts it through a valid/ready handshake.

## Interface

Parameters:
- `PC_WIDTH`, 10, program-counter and instruction-memory address width.
- `START_PC`, 0, PC loaded on `start`.
- `HALT_WORD`, 9'h1FF, instruction encoding that ends the program.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins fetching at `START_PC`.
- `imem_addr` out PC_WIDTH: instruction memory address; always equals `pc`.
- `imem_data` in 9: memory read data, valid in the cycle after the address is sampled.
- `instr` out 9: registered instruction word to the decoder's `bits` input.
- `instr_valid` out 1: `instr` is valid.
- `instr_ready` in 1: datapath accepts `instr` this cycle.
- `branchEnable` in 1: decoder branch-taken flag; sampled only on acceptance.
- `LUTIndex` in 5: decoder branch-target index; sampled only on acceptance.
- `lut_we` in 1: branch-target table write enable.
- `lut_waddr` in 5: table write index.
- `lut_wdata` in PC_WIDTH: table write data (target PC).
- `pc` out PC_WIDTH: PC of the current or pending instruction.
- `done` out 1: program halted.

## Operation

- States: IDLE, REQ, LOAD, HOLD, DONE.
- IDLE:
  - `start`=1 → `pc`←`START_PC`, go to REQ.
  - Otherwise stay in IDLE.
- REQ: `imem_addr`=`pc` is presented; memory samples it at the end of this cycle. Go to LOAD.
- LOAD: `instr`←`imem_data` at the end of this cycle. Go to HOLD.
- HOLD: `instr_valid`=1. `instr`, `pc` and `instr_valid` are held stable while `instr_ready`=0. Acceptance happens when `instr_ready`=1:
  - If `instr`==`HALT_WORD`, go to DONE; `pc` is unchanged.
  - Else, if `branchEnable`=1: `pc`←`lut[LUTIndex]`, go to REQ.
  - Else: `pc`←`pc`+1, modulo 2^PC_WIDTH (the all-ones address wraps to 0), go to REQ.
- DONE:
  - `done`=1 and `instr_valid`=0.
  - `start`=1 → clear `done`, `pc`←`START_PC`, go to REQ.
- `start` is ignored in REQ, LOAD and HOLD.
- Branch-target table:
  - 32 × PC_WIDTH registers, written whenever `lut_we`=1, in any state.
  - Reads are combinational from the registered contents.
  - A write and a branch read of the same index in the same cycle: the branch uses the old value; the new value is visible from the next cycle.

## Timing

- Reset values: state IDLE; `pc`=0; `imem_addr`=0; `instr`=0; `instr_valid`=0; `done`=0; all table entries 0.
- `reset` mid-operation: takes effect at the next edge regardless of state. A pending instruction is dropped and is not re-presented. Any `lut_we` in the same cycle is ignored.
- Latency:
  - `start` in cycle t gives REQ in t+1, LOAD in t+2, `instr_valid`=1 in t+3.
  - Acceptance in cycle u gives `instr_valid`=0 in u+1 (REQ) and the next `instr_valid`=1 in u+3.
  - Peak throughput is one instruction per 3 cycles.
- `instr_valid` never drops without acceptance or reset.
- `branchEnable` and `LUTIndex` are ignored in every cycle except an accepting HOLD cycle.
- In DONE, `pc` keeps the address of the HALT_WORD instruction.

## Test plan

- Reset, then `start` at cycle 1 with memory[0..2]=9'h003, 9'h004, HALT_WORD, `instr_ready`=1 tied high:
  - `instr`=9'h003 valid at cycle 4, 9'h004 at cycle 7, HALT_WORD at cycle 10.
  - `done`=1 from cycle 11 with `pc`=2.
- Table write index 5 = 10'h040. At `pc`=3, accept with `branchEnable`=1 and `LUTIndex`=5: next `imem_addr`=10'h040. A write to index 5 in that same cycle is not used.
- Hold `instr_ready`=0 for 4 cycles in HOLD while toggling `branchEnable` and `LUTIndex`: `instr` and `pc` remain stable. Release with `branchEnable`=0: `pc`+1 is fetched.
- `PC_WIDTH`=10, `pc`=10'h3FF, non-branch non-halt word accepted: next `imem_addr`=0.
- Assert `reset` during LOAD: next cycle shows IDLE, `instr_valid`=0, `pc`=0, table cleared. A following `start` produces the first instruction 3 cycles later.
- `start` pulsed in HOLD: ignored. `start` pulsed in DONE: `done`=0 next cycle, `imem_addr`=`START_PC`.
